// File: rtl/branch_predictor_gshare.sv
// Fetch-stage gshare predictor: 2-bit PHT indexed by PC^GHR, tagged direct-mapped BTB
// carrying branch type, and a speculative return address stack repaired from EX snapshots.
module branch_predictor_gshare #(
    parameter int SUPPORT_BRANCH_PREDICTION = 1,
    parameter int BTB_ENTRIES               = 32,
    parameter int BTB_IDX_W                 = 5,
    parameter int BTB_TAG_W                 = 20,
    parameter int PHT_ENTRIES               = 512,
    parameter int PHT_IDX_W                 = 9,
    parameter int GHR_W                     = 8,
    parameter int RAS_ENABLE                = 1,
    parameter int RAS_ENTRIES               = 8,
    parameter int RAS_PTR_W                 = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           invalidate_i,
    input  logic [31:0]                    pc_f_i,
    input  logic                           pc_accept_i,
    output logic [31:0]                    next_pc_o,
    output logic                           pred_taken_o,
    output logic [GHR_W-1:0]               ghr_o,
    output logic [RAS_PTR_W+RAS_PTR_W:0]   ras_snap_o,
    input  logic                           br_valid_i,
    input  logic [31:0]                    br_pc_i,
    input  logic [31:0]                    br_target_i,
    input  logic                           br_taken_i,
    input  logic [1:0]                     br_type_i,
    input  logic                           br_mispredict_i,
    input  logic [GHR_W-1:0]               br_ghr_i,
    input  logic [RAS_PTR_W+RAS_PTR_W:0]   br_ras_snap_i
);
    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_JMP  = 2'b01,
        BR_CALL = 2'b10,
        BR_RET  = 2'b11
    } br_type_e;

    localparam logic [RAS_PTR_W-1:0] PTR_ONE  = RAS_PTR_W'(1);
    localparam logic [RAS_PTR_W:0]   CNT_ONE  = (RAS_PTR_W+1)'(1);
    localparam logic [RAS_PTR_W:0]   CNT_FULL = (RAS_PTR_W+1)'(RAS_ENTRIES);

    logic                 r_btb_valid  [BTB_ENTRIES];
    logic [BTB_TAG_W-1:0] r_btb_tag    [BTB_ENTRIES];
    logic [31:0]          r_btb_target [BTB_ENTRIES];
    br_type_e             r_btb_type   [BTB_ENTRIES];
    logic [1:0]           r_pht        [PHT_ENTRIES];
    logic [31:0]          r_ras        [RAS_ENTRIES];
    logic [GHR_W-1:0]     r_ghr;
    logic [RAS_PTR_W-1:0] r_ras_ptr;
    logic [RAS_PTR_W:0]   r_ras_cnt;

    logic [BTB_IDX_W-1:0] w_btb_idx, w_br_btb_idx;
    logic [PHT_IDX_W-1:0] w_pht_idx, w_br_pht_idx;
    logic                 w_btb_hit, w_cond_taken, w_btb_we;
    br_type_e             w_hit_type, w_br_type;
    logic [31:0]          w_btb_target, w_pc_plus4, w_ras_top, w_next_pc;
    logic                 w_pred_taken;
    logic [1:0]           w_pht_old, w_pht_upd;
    logic [GHR_W-1:0]     w_ghr_nxt;
    logic [RAS_PTR_W-1:0] w_ras_base_ptr, w_ras_ptr_nxt;
    logic [RAS_PTR_W:0]   w_ras_base_cnt, w_ras_cnt_nxt;
    logic                 w_ras_push, w_ras_pop;
    logic [31:0]          w_ras_push_data;
    logic                 w_unused;

    assign w_btb_idx    = pc_f_i[BTB_IDX_W+1:2];
    assign w_btb_hit    = r_btb_valid[w_btb_idx] &&
                          (r_btb_tag[w_btb_idx] == pc_f_i[BTB_IDX_W+2 +: BTB_TAG_W]);
    assign w_hit_type   = r_btb_type[w_btb_idx];
    assign w_btb_target = r_btb_target[w_btb_idx];
    assign w_pht_idx    = pc_f_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(r_ghr);
    assign w_cond_taken = r_pht[w_pht_idx][1];
    assign w_pc_plus4   = pc_f_i + 32'd4;
    assign w_ras_top    = r_ras[r_ras_ptr - PTR_ONE];

    assign w_br_type    = br_type_e'(br_type_i);
    assign w_br_btb_idx = br_pc_i[BTB_IDX_W+1:2];
    assign w_br_pht_idx = br_pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(br_ghr_i);
    assign w_btb_we     = br_valid_i && (br_taken_i || (w_br_type != BR_COND));
    assign w_pht_old    = r_pht[w_br_pht_idx];
    assign w_pht_upd    = br_taken_i ? ((w_pht_old == 2'b11) ? w_pht_old : w_pht_old + 2'b01)
                                     : ((w_pht_old == 2'b00) ? w_pht_old : w_pht_old - 2'b01);

    // Bits of the PCs that neither the index nor the tag consumes.
    assign w_unused = &{1'b0, pc_f_i[1:0], br_pc_i[1:0],
                        pc_f_i[31:BTB_IDX_W+2+BTB_TAG_W], br_pc_i[31:BTB_IDX_W+2+BTB_TAG_W]};

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_pc    = w_pc_plus4;
        w_pred_taken = 1'b0;
        if ((SUPPORT_BRANCH_PREDICTION != 0) && w_btb_hit) begin
            case (w_hit_type)
                BR_COND: begin
                    w_pred_taken = w_cond_taken;
                    if (w_cond_taken) w_next_pc = w_btb_target;
                end
                BR_JMP, BR_CALL: begin
                    w_pred_taken = 1'b1;
                    w_next_pc    = w_btb_target;
                end
                default: begin
                    w_pred_taken = 1'b1;
                    w_next_pc    = ((RAS_ENABLE != 0) && (r_ras_cnt != '0)) ? w_ras_top : w_btb_target;
                end
            endcase
        end
    end

    // A mispredict rebuilds GHR/RAS from the branch's snapshot and replays only that
    // branch's own effect; the concurrent fetch is on the wrong path and is dropped.
    always_comb begin
        w_ghr_nxt       = r_ghr;
        w_ras_base_ptr  = r_ras_ptr;
        w_ras_base_cnt  = r_ras_cnt;
        w_ras_push      = 1'b0;
        w_ras_pop       = 1'b0;
        w_ras_push_data = w_pc_plus4;
        if (br_valid_i && br_mispredict_i) begin
            w_ghr_nxt       = (w_br_type == BR_COND) ? GHR_W'({br_ghr_i, br_taken_i}) : br_ghr_i;
            w_ras_base_ptr  = br_ras_snap_i[RAS_PTR_W+RAS_PTR_W -: RAS_PTR_W];
            w_ras_base_cnt  = br_ras_snap_i[RAS_PTR_W:0];
            w_ras_push      = (w_br_type == BR_CALL);
            w_ras_pop       = (w_br_type == BR_RET);
            w_ras_push_data = br_pc_i + 32'd4;
        end else if (pc_accept_i && w_btb_hit) begin
            if (w_hit_type == BR_COND) w_ghr_nxt = GHR_W'({r_ghr, w_cond_taken});
            w_ras_push = (w_hit_type == BR_CALL);
            w_ras_pop  = (w_hit_type == BR_RET);
        end

        w_ras_ptr_nxt = w_ras_base_ptr;
        w_ras_cnt_nxt = w_ras_base_cnt;
        if (w_ras_push) begin
            w_ras_ptr_nxt = w_ras_base_ptr + PTR_ONE;
            if (w_ras_base_cnt != CNT_FULL) w_ras_cnt_nxt = w_ras_base_cnt + CNT_ONE;
        end else if (w_ras_pop && (w_ras_base_cnt != '0)) begin
            w_ras_ptr_nxt = w_ras_base_ptr - PTR_ONE;
            w_ras_cnt_nxt = w_ras_base_cnt - CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || invalidate_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) r_btb_valid[i] <= 1'b0;
            for (int i = 0; i < PHT_ENTRIES; i++) r_pht[i] <= 2'b01;
            r_ghr     <= '0;
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else if (SUPPORT_BRANCH_PREDICTION != 0) begin
            r_ghr <= w_ghr_nxt;
            if (RAS_ENABLE != 0) begin
                r_ras_ptr <= w_ras_ptr_nxt;
                r_ras_cnt <= w_ras_cnt_nxt;
            end
            if (br_valid_i && (w_br_type == BR_COND)) r_pht[w_br_pht_idx] <= w_pht_upd;
            if (w_btb_we) r_btb_valid[w_br_btb_idx] <= 1'b1;
        end
    end

    // NOTE: payload arrays carry no reset; valid bits and the RAS count gate every read.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !invalidate_i && (SUPPORT_BRANCH_PREDICTION != 0)) begin
            if (w_btb_we) begin
                r_btb_tag[w_br_btb_idx]    <= br_pc_i[BTB_IDX_W+2 +: BTB_TAG_W];
                r_btb_target[w_br_btb_idx] <= br_target_i;
                r_btb_type[w_br_btb_idx]   <= w_br_type;
            end
            if ((RAS_ENABLE != 0) && w_ras_push) r_ras[w_ras_base_ptr] <= w_ras_push_data;
        end
    end

    assign next_pc_o    = w_next_pc;
    assign pred_taken_o = w_pred_taken;
    assign ghr_o        = r_ghr;
    assign ras_snap_o   = {r_ras_ptr, r_ras_cnt};
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Bench for branch_predictor_gshare: a table/stack model checked every cycle, plus
// hand-computed expectations from the directed scenarios.
module tb_branch_predictor_gshare;
    localparam logic [1:0] T_COND = 2'b00, T_JMP = 2'b01, T_CALL = 2'b10, T_RET = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n, invalidate, pc_accept, br_valid, br_taken, br_mispredict;
    logic [31:0] pc_f, br_pc, br_target, next_pc;
    logic        pred_taken;
    logic [1:0]  br_type;
    logic [7:0]  ghr, br_ghr;
    logic [6:0]  ras_snap, br_ras_snap;

    always #5 clk = ~clk;

    branch_predictor_gshare dut (
        .clk_i(clk), .rst_ni(rst_n), .invalidate_i(invalidate),
        .pc_f_i(pc_f), .pc_accept_i(pc_accept),
        .next_pc_o(next_pc), .pred_taken_o(pred_taken), .ghr_o(ghr), .ras_snap_o(ras_snap),
        .br_valid_i(br_valid), .br_pc_i(br_pc), .br_target_i(br_target), .br_taken_i(br_taken),
        .br_type_i(br_type), .br_mispredict_i(br_mispredict), .br_ghr_i(br_ghr),
        .br_ras_snap_i(br_ras_snap)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: BTB remembers the full branch PC per slot, PHT holds counter values 0..3,
    // RAS is a circular array of 8 return addresses with an occupancy count.
    bit          m_valid  [32];
    logic [31:0] m_pc     [32];
    logic [31:0] m_target [32];
    logic [1:0]  m_type   [32];
    int          m_pht    [512];
    logic [31:0] m_ras    [8];
    int          m_ghr, m_ptr, m_cnt;

    function automatic void m_predict(input logic [31:0] pc, output bit hit, output logic [1:0] typ,
                                      output logic [31:0] nxt, output bit tk);
        int e = int'(pc[6:2]);
        int p = int'(pc[10:2]) ^ m_ghr;
        hit = m_valid[e] && (m_pc[e][26:7] == pc[26:7]);
        typ = m_type[e];
        nxt = pc + 32'd4;
        tk  = 1'b0;
        if (hit) begin
            if (typ == T_COND) begin
                tk = (m_pht[p] >= 2);
                if (tk) nxt = m_target[e];
            end else if (typ == T_RET && m_cnt > 0) begin
                tk  = 1'b1;
                nxt = m_ras[(m_ptr + 7) % 8];
            end else begin
                tk  = 1'b1;
                nxt = m_target[e];
            end
        end
    endfunction

    function automatic void m_push(input logic [31:0] d);
        m_ras[m_ptr] = d;
        m_ptr = (m_ptr + 1) % 8;
        if (m_cnt < 8) m_cnt++;
    endfunction

    function automatic void m_pop();
        if (m_cnt > 0) begin
            m_ptr = (m_ptr + 7) % 8;
            m_cnt--;
        end
    endfunction

    always @(posedge clk) begin
        bit          hit, tk;
        logic [1:0]  typ;
        logic [31:0] nxt;
        int          p, e;
        if (!rst_n || invalidate) begin
            for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
            for (int i = 0; i < 512; i++) m_pht[i] = 1;
            m_ghr = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            m_predict(pc_f, hit, typ, nxt, tk);
            if (br_valid && br_mispredict) begin
                m_ghr = (br_type == T_COND) ? ((int'(br_ghr) * 2 + int'(br_taken)) % 256) : int'(br_ghr);
                m_ptr = int'(br_ras_snap[6:4]);
                m_cnt = int'(br_ras_snap[3:0]);
                if (br_type == T_CALL) m_push(br_pc + 32'd4);
                else if (br_type == T_RET) m_pop();
            end else if (pc_accept && hit) begin
                if (typ == T_COND) m_ghr = (m_ghr * 2 + int'(tk)) % 256;
                else if (typ == T_CALL) m_push(pc_f + 32'd4);
                else if (typ == T_RET) m_pop();
            end
            if (br_valid) begin
                if (br_type == T_COND) begin
                    p = int'(br_pc[10:2]) ^ int'(br_ghr);
                    if (br_taken && m_pht[p] < 3) m_pht[p]++;
                    else if (!br_taken && m_pht[p] > 0) m_pht[p]--;
                end
                if (br_taken || br_type != T_COND) begin
                    e = int'(br_pc[6:2]);
                    m_valid[e]  = 1'b1;
                    m_pc[e]     = br_pc;
                    m_target[e] = br_target;
                    m_type[e]   = br_type;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit          hit, tk;
        logic [1:0]  typ;
        logic [31:0] nxt;
        logic [2:0]  eptr;
        logic [3:0]  ecnt;
        if (chk_en) begin
            m_predict(pc_f, hit, typ, nxt, tk);
            eptr = m_ptr[2:0];
            ecnt = m_cnt[3:0];
            check("model_next_pc", next_pc, nxt);
            check("model_pred_taken", {31'd0, pred_taken}, {31'd0, tk});
            check("model_ghr", {24'd0, ghr}, m_ghr);
            check("model_ras_snap", {25'd0, ras_snap}, {25'd0, eptr, ecnt});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                           input logic [1:0] typ, input logic mis, input logic [7:0] g,
                           input logic [6:0] snap);
        br_pc = pc; br_target = tgt; br_taken = tk; br_type = typ;
        br_mispredict = mis; br_ghr = g; br_ras_snap = snap; br_valid = 1'b1;
        tick();
        br_valid = 1'b0; br_mispredict = 1'b0;
    endtask

    task automatic fetch_chk(input string name, input logic [31:0] pc, input logic acc,
                             input logic [31:0] exp_next, input logic exp_tk);
        pc_f = pc; pc_accept = acc;
        #1;
        check({name, "_next"}, next_pc, exp_next);
        check({name, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        tick();
        pc_accept = 1'b0;
    endtask

    task automatic chk_state(input string name, input logic [7:0] exp_ghr, input logic [6:0] exp_snap);
        #1;
        check({name, "_ghr"}, {24'd0, ghr}, {24'd0, exp_ghr});
        check({name, "_snap"}, {25'd0, ras_snap}, {25'd0, exp_snap});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; invalidate = 1'b0; pc_f = 32'h100; pc_accept = 1'b0;
        br_valid = 1'b0; br_pc = '0; br_target = '0; br_taken = 1'b0; br_type = T_COND;
        br_mispredict = 1'b0; br_ghr = '0; br_ras_snap = '0;
        tick();
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset state
        #1;
        check("reset_next", next_pc, 32'h104);
        check("reset_taken", {31'd0, pred_taken}, 32'd0);
        chk_state("reset", 8'h00, 7'h00);

        // COND trained taken twice, then predicted taken and shifted into GHR
        resolve(32'h200, 32'h80, 1'b1, T_COND, 1'b0, 8'h00, 7'h00);
        resolve(32'h200, 32'h80, 1'b1, T_COND, 1'b0, 8'h00, 7'h00);
        fetch_chk("cond", 32'h200, 1'b1, 32'h80, 1'b1);
        chk_state("cond", 8'h01, 7'h00);

        // CALL then RET: RET returns from the RAS, not the BTB target
        resolve(32'h300, 32'h1000, 1'b1, T_CALL, 1'b0, 8'h00, 7'h00);
        resolve(32'h1010, 32'h999, 1'b1, T_RET, 1'b0, 8'h00, 7'h00);
        fetch_chk("call", 32'h300, 1'b1, 32'h1000, 1'b1);
        chk_state("call", 8'h01, 7'h11);
        fetch_chk("ret", 32'h1010, 1'b1, 32'h304, 1'b1);
        chk_state("ret", 8'h01, 7'h00);

        // Nine CALLs overflow an 8-deep RAS; pops come back newest first
        for (int i = 0; i < 9; i++)
            resolve(32'h440 + 32'(4 * i), 32'h5000 + 32'(16 * i), 1'b1, T_CALL, 1'b0, 8'h00, 7'h00);
        for (int i = 0; i < 9; i++)
            fetch_chk("ovf_call", 32'h440 + 32'(4 * i), 1'b1, 32'h5000 + 32'(16 * i), 1'b1);
        chk_state("ovf_full", 8'h01, 7'h18);
        for (int j = 0; j < 8; j++)
            fetch_chk("ovf_ret", 32'h1010, 1'b1, 32'h464 - 32'(4 * j), 1'b1);
        fetch_chk("empty_ret", 32'h1010, 1'b1, 32'h999, 1'b1);
        chk_state("ovf_empty", 8'h01, 7'h10);

        // Mispredict repair beats a concurrent accepted COND fetch
        resolve(32'h600, 32'h6000, 1'b1, T_COND, 1'b0, 8'h00, 7'h00);
        resolve(32'h7070, 32'h7700, 1'b1, T_JMP, 1'b1, 8'h5A, 7'h10);
        chk_state("jmp_repair", 8'h5A, 7'h10);
        br_pc = 32'h700; br_target = 32'h0; br_taken = 1'b0; br_type = T_COND;
        br_mispredict = 1'b1; br_ghr = 8'h12; br_ras_snap = 7'h10; br_valid = 1'b1;
        fetch_chk("mis_cond", 32'h600, 1'b1, 32'h604, 1'b0);
        br_valid = 1'b0; br_mispredict = 1'b0;
        chk_state("mis_cond", 8'h24, 7'h10);

        // CALL and RET repairs apply their own push/pop on top of the snapshot
        resolve(32'h900, 32'h9000, 1'b1, T_CALL, 1'b1, 8'h24, 7'h00);
        chk_state("mis_call", 8'h24, 7'h11);
        fetch_chk("mis_call_ret", 32'h1010, 1'b1, 32'h904, 1'b1);
        chk_state("mis_call_ret", 8'h24, 7'h00);
        resolve(32'h1010, 32'h999, 1'b1, T_RET, 1'b1, 8'h24, 7'h32);
        chk_state("mis_ret", 8'h24, 7'h21);

        // Invalidate wins over a same-cycle resolution write
        invalidate = 1'b1;
        resolve(32'h800, 32'h1234, 1'b1, T_JMP, 1'b0, 8'h00, 7'h00);
        invalidate = 1'b0;
        chk_state("inval", 8'h00, 7'h00);
        fetch_chk("inval_jmp", 32'h800, 1'b0, 32'h804, 1'b0);
        fetch_chk("inval_ret", 32'h1010, 1'b0, 32'h1014, 1'b0);
        fetch_chk("inval_call", 32'h444, 1'b0, 32'h448, 1'b0);
        fetch_chk("inval_cond", 32'h600, 1'b0, 32'h604, 1'b0);

        // PHT back at weakly-not-taken: one taken then one not-taken leaves it not taken
        resolve(32'h600, 32'h6000, 1'b1, T_COND, 1'b0, 8'h00, 7'h00);
        resolve(32'h600, 32'h6000, 1'b0, T_COND, 1'b0, 8'h00, 7'h00);
        fetch_chk("pht_cleared", 32'h600, 1'b0, 32'h604, 1'b0);

        tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
Next-generation fetch-stage predictor for the superscalar core. It combines a gshare PHT (2-bit counters indexed by PC XOR global history), a tagged direct-mapped BTB that records branch type, and a speculative return address stack (RAS) with checkpoint/restore on mispredict. Prediction is combinational from pc_f_i. Speculative state advances on fetch accept and is repaired from EX-stage resolution.

Parameters:
SUPPORT_BRANCH_PREDICTION, 1, 0: next_pc_o = pc_f_i+4, pred_taken_o = 0, no state updates
BTB_ENTRIES, 32, BTB depth
BTB_IDX_W, 5, log2(BTB_ENTRIES)
BTB_TAG_W, 20, tag bits taken from pc[BTB_IDX_W+2 +: BTB_TAG_W]
PHT_ENTRIES, 512, number of 2-bit counters
PHT_IDX_W, 9, log2(PHT_ENTRIES)
GHR_W, 8, global history length; must be ≤ PHT_IDX_W
RAS_ENABLE, 1, 0: RET entries predicted from BTB target, RAS never changes
RAS_ENTRIES, 8, RAS depth
RAS_PTR_W, 3, log2(RAS_ENTRIES)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
invalidate_i  in  1  flush all predictor state
pc_f_i  in  32  fetch PC
pc_accept_i  in  1  fetch PC consumed this cycle; commit speculative updates
next_pc_o  out  32  predicted next PC
pred_taken_o  out  1  prediction is taken
ghr_o  out  GHR_W  GHR snapshot for this fetch, carried down the pipe
ras_snap_o  out  RAS_PTR_W+RAS_PTR_W+1  {ras_ptr, ras_cnt} snapshot for this fetch
br_valid_i  in  1  resolution valid
br_pc_i  in  32  PC of the resolved branch
br_target_i  in  32  resolved target
br_taken_i  in  1  resolved direction
br_type_i  in  2  branch type: 00 COND, 01 JMP, 10 CALL, 11 RET
br_mispredict_i  in  1  fetch redirect; repair speculative state
br_ghr_i  in  GHR_W  ghr_o snapshot carried with the branch
br_ras_snap_i  in  RAS_PTR_W+RAS_PTR_W+1  ras_snap_o snapshot carried with the branch

Behaviour:
- Reset (rst_ni=0 at posedge): all BTB valid bits = 0; all PHT entries = 2'b01; ghr = 0; ras_ptr = 0; ras_cnt = 0. Outputs after reset: next_pc_o = pc_f_i+4, pred_taken_o = 0, ghr_o = 0, ras_snap_o = 0.
- invalidate_i: same clearing as reset, applied at the next edge. Priority is reset > invalidate > mispredict repair > fetch speculation. Resolution table writes in an invalidate cycle are dropped.
- BTB lookup: idx = pc_f_i[BTB_IDX_W+1:2]; hit = valid[idx] and tag[idx] == pc_f_i[BTB_IDX_W+2 +: BTB_TAG_W].
- PHT lookup: index = pc_f_i[PHT_IDX_W+1:2] XOR zero-extended ghr.
- Prediction, all combinational with 0 latency:
  - miss: next = pc+4, not taken.
  - hit COND: taken = pht[1]; next = taken ? target : pc+4.
  - hit JMP or CALL: taken, next = target.
  - hit RET: taken; next = RAS top if RAS_ENABLE and ras_cnt != 0, else BTB target.
- Fetch speculation, on pc_accept_i with no mispredict in the same cycle:
  - hit COND: ghr <= {ghr[GHR_W-2:0], taken}.
  - hit CALL: push pc_f_i+4 at ras_ptr; ptr+1 (wraps); cnt saturates at RAS_ENTRIES. On overflow the oldest entry is overwritten.
  - hit RET with cnt != 0: ptr-1, cnt-1. Pop when empty leaves the RAS unchanged.
- ghr_o and ras_snap_o always reflect pre-update state.
- Resolution, when br_valid_i is high:
  - PHT update: index = br_pc_i[PHT_IDX_W+1:2] XOR br_ghr_i; COND only; saturating +1 if taken, -1 if not.
  - BTB write at br_pc_i index/tag when br_taken_i or type != COND: target, type, valid = 1. A not-taken COND leaves the BTB unchanged.
- Mispredict repair (br_valid_i and br_mispredict_i):
  - ghr <= COND ? {br_ghr_i[GHR_W-2:0], br_taken_i} : br_ghr_i.
  - RAS ptr/cnt <= br_ras_snap_i, then the branch's own effect is applied in the same cycle: CALL pushes br_pc_i+4; RET pops if the restored cnt != 0.
  - Fetch speculation in that cycle is discarded.
- Same-cycle lookup and table write: the lookup sees old contents (read-before-write).
- Arithmetic: PC+4 is 32-bit modulo; the RAS pointer wraps modulo RAS_ENTRIES.

Test Plan:
1. Reset, pc_f_i=0x100 -> next_pc_o=0x104, pred_taken_o=0, ghr_o=0.
2. Resolve COND taken at 0x200, target 0x80, br_ghr_i=0, twice -> PHT index 0x80 = 2'b11; fetch 0x200 with ghr=0 -> next 0x80, taken; after accept ghr=0x01.
3. Resolve CALL at 0x300 (target 0x1000) and RET at 0x1010 (target 0x999). Fetch-accept 0x300 -> ras_cnt=1. Fetch 0x1010 -> next_pc_o=0x304 (not 0x999); after accept ras_cnt=0.
4. Nine accepted CALL fetches with RAS_ENTRIES=8 -> cnt=8, first return address lost; eight RET fetches return addresses newest-first; ninth RET uses BTB target.
5. Speculative ghr=0x5A, mispredict on COND with br_ghr_i=0x12, taken=0, concurrent accepted hit COND -> ghr=0x24, fetch speculation ignored.
6. Populate BTB/PHT, pulse invalidate_i with br_valid_i high -> all lookups miss, ghr=0, RAS empty, resolution write absent.
